// File: rtl/cnn_pkg.sv
// Shared FP32 helpers for the CNN datapath blocks: element width, the
// order-preserving sort key used for float compares, and the +0.0 pattern.
package cnn_pkg;

  localparam int FP32_W = 32;

  localparam logic [FP32_W-1:0] FP_POS_ZERO = '0;

  // Maps an FP32 pattern to an unsigned key whose integer order matches the
  // float order (-inf lowest, -0.0 just below +0.0).
  function automatic logic [FP32_W-1:0] fp_key(input logic [FP32_W-1:0] x);
    return x[FP32_W-1] ? ~x : {1'b1, x[FP32_W-2:0]};
  endfunction

endpackage

// File: rtl/fp_max.sv
// Combinational FP32 maximum; on equal keys the first operand is returned.
module fp_max
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = FP32_W
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] max_val
);

  assign max_val = (fp_key(b) > fp_key(a)) ? b : a;

endmodule

// File: rtl/max_pooling_2x2.sv
// Streaming 2x2/stride-2 FP32 max pooling over raster-ordered feature maps.
// Optional build macro MAX_POOLING_RELU_EN fuses a ReLU after pooling.
module max_pooling_2x2
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = FP32_W,
  parameter int INPUT      = 30,
  parameter int DEPTH      = 1
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  ready_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  ready_i,
  output logic                  frame_done_o
);

  localparam int HALF  = INPUT / 2;
  localparam int COL_W = (INPUT > 1) ? $clog2(INPUT) : 1;
  localparam int CH_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LB_W  = (HALF > 1) ? $clog2(HALF) : 1;

  logic [COL_W-1:0]      col_p0;
  logic [COL_W-1:0]      row_p0;
  logic [CH_W-1:0]       ch_p0;
  logic [DATA_WIDTH-1:0] hold_p0;
  logic [DATA_WIDTH-1:0] linebuf_p0 [HALF];

  logic [DATA_WIDTH-1:0] out_data_p1;
  logic                  vld_p1;
  logic                  last_p1;

  logic                  accept;
  logic                  load;
  logic                  last_col;
  logic                  last_row;
  logic                  last_ch;
  logic [LB_W-1:0]       lb_idx;
  logic [DATA_WIDTH-1:0] cmp_a;
  logic [DATA_WIDTH-1:0] cmp_max;

  function automatic logic [DATA_WIDTH-1:0] relu(input logic [DATA_WIDTH-1:0] x);
`ifdef MAX_POOLING_RELU_EN
    return x[DATA_WIDTH-1] ? DATA_WIDTH'(FP_POS_ZERO) : x;
`else
    return x;
`endif
  endfunction

  assign ready_o      = !vld_p1 || ready_i;
  assign accept       = valid_i && ready_o;
  assign load         = accept && row_p0[0] && col_p0[0];
  assign last_col     = (col_p0 == COL_W'(INPUT - 1));
  assign last_row     = (row_p0 == COL_W'(INPUT - 1));
  assign last_ch      = (ch_p0 == CH_W'(DEPTH - 1));
  assign lb_idx       = LB_W'(col_p0 >> 1);

  // Only the odd-row/even-col case compares against the line buffer.
  assign cmp_a = (row_p0[0] && !col_p0[0]) ? linebuf_p0[lb_idx] : hold_p0;

  fp_max #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_fp_max (
    .a      (cmp_a),
    .b      (data_i),
    .max_val(cmp_max)
  );

  // p0: raster position counters and window accumulation
  always_ff @(posedge clk) begin
    if (rst_i) begin
      col_p0  <= '0;
      row_p0  <= '0;
      ch_p0   <= '0;
      hold_p0 <= '0;
    end else if (accept) begin
      if (!col_p0[0]) hold_p0 <= row_p0[0] ? cmp_max : data_i;
      if (last_col) begin
        col_p0 <= '0;
        if (last_row) begin
          row_p0 <= '0;
          ch_p0  <= last_ch ? '0 : ch_p0 + CH_W'(1);
        end else begin
          row_p0 <= row_p0 + COL_W'(1);
        end
      end else begin
        col_p0 <= col_p0 + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !row_p0[0] && col_p0[0]) linebuf_p0[lb_idx] <= cmp_max;
  end

  // p1: output register with valid/ready hold
  always_ff @(posedge clk) begin
    if (rst_i) begin
      out_data_p1 <= '0;
      vld_p1      <= 1'b0;
      last_p1     <= 1'b0;
    end else if (load) begin
      out_data_p1 <= relu(cmp_max);
      vld_p1      <= 1'b1;
      last_p1     <= last_col && last_row && last_ch;
    end else if (vld_p1 && ready_i) begin
      vld_p1      <= 1'b0;
      last_p1     <= 1'b0;
    end
  end

  assign valid_o      = vld_p1;
  assign data_o       = out_data_p1;
  assign frame_done_o = vld_p1 && ready_i && last_p1;

endmodule

// File: tb/tb_max_pooling_2x2.sv
// Bench for max_pooling_2x2: three instances (4x4x1, 4x4x2, 30x30x1) driven in turn.
module tb_max_pooling_2x2;

  logic        clk;
  logic        rst;
  logic        valid;
  logic        ready;
  logic [31:0] din;
  logic [1:0]  sel;

  logic        ro0, vo0, fd0, ro1, vo1, fd1, ro2, vo2, fd2;
  logic [31:0] do0, do1, do2;
  logic        cur_ro, cur_vo, cur_fd;
  logic [31:0] cur_do;

  int          n_pass;
  int          n_fail;
  int          n_total;
  int          cur_in;
  logic [31:0] stim[$];
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  max_pooling_2x2 #(.DATA_WIDTH(32), .INPUT(4), .DEPTH(1)) u_dut0 (
    .clk(clk), .rst_i(rst), .valid_i(valid && sel == 2'd0), .data_i(din),
    .ready_o(ro0), .valid_o(vo0), .data_o(do0), .ready_i(ready), .frame_done_o(fd0));

  max_pooling_2x2 #(.DATA_WIDTH(32), .INPUT(4), .DEPTH(2)) u_dut1 (
    .clk(clk), .rst_i(rst), .valid_i(valid && sel == 2'd1), .data_i(din),
    .ready_o(ro1), .valid_o(vo1), .data_o(do1), .ready_i(ready), .frame_done_o(fd1));

  max_pooling_2x2 #(.DATA_WIDTH(32), .INPUT(30), .DEPTH(1)) u_dut2 (
    .clk(clk), .rst_i(rst), .valid_i(valid && sel == 2'd2), .data_i(din),
    .ready_o(ro2), .valid_o(vo2), .data_o(do2), .ready_i(ready), .frame_done_o(fd2));

  always_comb begin
    cur_ro = ro0; cur_vo = vo0; cur_do = do0; cur_fd = fd0;
    case (sel)
      2'd1: begin cur_ro = ro1; cur_vo = vo1; cur_do = do1; cur_fd = fd1; end
      2'd2: begin cur_ro = ro2; cur_vo = vo2; cur_do = do2; cur_fd = fd2; end
      default: ;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Integer -> FP32 bit pattern (exact for |k| < 2^24).
  function automatic logic [31:0] fp(input int k);
    logic [31:0] a;
    logic [31:0] m;
    int msb;
    if (k == 0) return 32'h0;
    a = (k < 0) ? 32'(-k) : 32'(k);
    msb = 0;
    for (int i = 0; i < 24; i++) if (a[i]) msb = i;
    m = a << (23 - msb);
    return {k < 0, 8'(127 + msb), m[22:0]};
  endfunction

  // Float ordering from sign/magnitude rules: negative below positive,
  // larger magnitude is larger for positives and smaller for negatives.
  function automatic bit fp_less(input logic [31:0] a, input logic [31:0] b);
    if (a[31] != b[31]) return a[31];
    if (!a[31]) return a[30:0] < b[30:0];
    return a[30:0] > b[30:0];
  endfunction

  function automatic void build_exp(input int side, input int depth);
    logic [31:0] w[4];
    logic [31:0] m;
    int base;
    exp_q.delete();
    for (int c = 0; c < depth; c++)
      for (int r = 0; r < side; r += 2)
        for (int k = 0; k < side; k += 2) begin
          base = c * side * side + r * side + k;
          w[0] = stim[base];        w[1] = stim[base + 1];
          w[2] = stim[base + side]; w[3] = stim[base + side + 1];
          m = w[0];
          for (int j = 1; j < 4; j++) if (fp_less(m, w[j])) m = w[j];
`ifdef MAX_POOLING_RELU_EN
          if (m[31]) m = 32'h0;
`endif
          exp_q.push_back(m);
        end
  endfunction

  // Input count at which output k is expected with back-to-back traffic.
  function automatic int trig(input int k);
    int h, w;
    h = cur_in / 2;
    w = k % (h * h);
    return (k / (h * h)) * cur_in * cur_in + (2 * (w / h) + 1) * cur_in + 2 * (w % h) + 2;
  endfunction

  // mode 0: ready_i=1; mode 1: random ready_i; mode 2: 5-cycle stall on first output.
  task automatic run_stream(input string name, input int mode, input int vgap,
                            input bit chk_lat, input int budget);
    int in_idx, out_idx, cyc, stall_left;
    bit stall_done, xfer;
    logic [31:0] held;
    in_idx = 0; out_idx = 0; cyc = 0; stall_left = 0; stall_done = 0; held = '0;
    got_q.delete();
    while ((in_idx < stim.size() || out_idx < exp_q.size()) && cyc < budget) begin
      @(negedge clk);
      valid = (in_idx < stim.size()) && ($urandom_range(99) >= vgap);
      din   = (in_idx < stim.size()) ? stim[in_idx] : $urandom;
      if (mode == 2 && !stall_done && stall_left == 0 && cur_vo) begin
        stall_left = 5;
        held = cur_do;
      end
      if (stall_left > 0) ready = 1'b0;
      else if (mode == 1) ready = ($urandom_range(99) >= 35);
      else ready = 1'b1;
      #1;
      if (stall_left > 0) begin
        check({name, "_stall_vld"}, 32'(cur_vo), 32'd1);
        check({name, "_stall_data"}, cur_do, held);
        check({name, "_stall_ready"}, 32'(cur_ro), 32'd0);
        stall_left--;
        if (stall_left == 0) stall_done = 1;
      end
      xfer = cur_vo && ready;
      check({name, "_frame_done"}, 32'(cur_fd),
            32'(xfer && out_idx == exp_q.size() - 1));
      if (xfer) begin
        if (out_idx < exp_q.size()) begin
          check($sformatf("%s_out%0d", name, out_idx), cur_do, exp_q[out_idx]);
          if (chk_lat) check($sformatf("%s_lat%0d", name, out_idx), 32'(in_idx), 32'(trig(out_idx)));
        end else begin
          check({name, "_extra_out"}, cur_do, 32'hxxxxxxxx);
        end
        got_q.push_back(cur_do);
        out_idx++;
      end
      if (valid && cur_ro) in_idx++;
      cyc++;
    end
    check({name, "_inputs_taken"}, 32'(in_idx), 32'(stim.size()));
    check({name, "_outputs_seen"}, 32'(out_idx), 32'(exp_q.size()));
    @(negedge clk);
    valid = 1'b0;
    ready = 1'b1;
    repeat (3) @(negedge clk);
    check({name, "_idle_after"}, 32'(cur_vo), 32'd0);
  endtask

  function automatic logic [31:0] rand_fp();
    logic [31:0] r;
    r = $urandom;
    if (r[30:23] == 8'hFF) r[22:0] = '0;
    if ($urandom_range(15) == 0) r = {r[31], 31'b0};
    return r;
  endfunction

  initial begin
    int k;
    n_pass = 0; n_fail = 0; n_total = 0;
    sel = 2'd0; rst = 1'b1; valid = 1'b0; ready = 1'b0; din = '0; cur_in = 4;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #1;
      check($sformatf("reset_vld%0d", s), 32'(cur_vo), 32'd0);
      check($sformatf("reset_ready%0d", s), 32'(cur_ro), 32'd1);
      check($sformatf("reset_data%0d", s), cur_do, 32'd0);
      check($sformatf("reset_fd%0d", s), 32'(cur_fd), 32'd0);
    end
    rst = 1'b0;

    // 4x4 ramp, continuous traffic
    sel = 2'd0; cur_in = 4;
    stim.delete();
    for (int i = 1; i <= 16; i++) stim.push_back(fp(i));
    exp_q = '{fp(6), fp(8), fp(14), fp(16)};
    run_stream("ramp", 0, 0, 1, 100);

    // signed-zero / -inf windows
    stim = '{fp(-3), fp(-1), 32'h8000_0000, 32'h0000_0000,
             fp(-2), 32'h8000_0000, fp(-1), 32'hFF80_0000,
             fp(5), fp(9), fp(2), fp(7), fp(3), fp(1), fp(11), fp(4)};
    build_exp(4, 1);
    run_stream("zeros", 1, 20, 0, 200);
    if (got_q.size() >= 2) begin
`ifdef MAX_POOLING_RELU_EN
      check("neg_zero_win", got_q[0], 32'h0000_0000);
`else
      check("neg_zero_win", got_q[0], 32'h8000_0000);
`endif
      check("pos_zero_win", got_q[1], 32'h0000_0000);
    end else begin
      check("zeros_count", 32'(got_q.size()), 32'd2);
    end

    // output stall with ready_i low
    stim.delete();
    for (int i = 1; i <= 16; i++) stim.push_back(fp(i));
    exp_q = '{fp(6), fp(8), fp(14), fp(16)};
    run_stream("stall", 2, 0, 0, 200);

    // two channels
    sel = 2'd1;
    stim.delete();
    for (int i = 1; i <= 16; i++) stim.push_back(fp(i));
    for (int i = 1; i <= 16; i++) stim.push_back(fp(i + 100));
    exp_q = '{fp(6), fp(8), fp(14), fp(16), fp(106), fp(108), fp(114), fp(116)};
    run_stream("depth2", 0, 0, 1, 200);

    // reset mid-frame discards the pending output and partial windows
    sel = 2'd0; ready = 1'b0; k = 0;
    for (int c = 0; c < 40 && k < 6; c++) begin
      @(negedge clk);
      valid = 1'b1; din = fp(k + 1);
      #1;
      if (cur_ro) k++;
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      valid = 1'b1; din = fp(7);
      #1;
      check("midframe_ready", 32'(cur_ro), 32'd0);
      check("midframe_pending", cur_do, fp(6));
    end
    @(negedge clk);
    valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_reset_vld", 32'(cur_vo), 32'd0);
    check("post_reset_ready", 32'(cur_ro), 32'd1);
    stim.delete();
    for (int i = 1; i <= 16; i++) stim.push_back(fp(50 - i));
    exp_q = '{fp(49), fp(47), fp(41), fp(39)};
    run_stream("after_rst", 0, 0, 1, 100);

    // 30x30 random values with random valid/ready gaps
    sel = 2'd2; cur_in = 30;
    stim.delete();
    for (int i = 0; i < 900; i++) stim.push_back(rand_fp());
    build_exp(30, 1);
    run_stream("rand30", 1, 30, 0, 20000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
